// File: rtl/ram_sp_arbiter_pkg.sv
// Shared types for the single-port RAM arbiter: controller states, port count and port id.
package ram_arb_pkg;

    localparam int NUM_PORTS = 2;

    typedef logic [$clog2(NUM_PORTS)-1:0] port_id_t;

    typedef enum logic [1:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR
    } state_t;

    function automatic port_id_t grant_to_id(input logic [NUM_PORTS-1:0] grant);
        return port_id_t'(grant[1]);
    endfunction

endpackage

// File: rtl/ram_sp_arbiter_if.sv
// Requester-side valid/ready request and response bundle for ram_sp_arbiter.
interface ram_sp_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32
);

    logic [NUM_PORTS-1:0]  req_valid;
    logic [NUM_PORTS-1:0]  req_ready;
    logic [NUM_PORTS-1:0]  req_we;
    logic [ADDR_WIDTH-1:0] req_addr0;
    logic [ADDR_WIDTH-1:0] req_addr1;
    logic [DATA_WIDTH-1:0] req_wdata0;
    logic [DATA_WIDTH-1:0] req_wdata1;
    logic [NUM_PORTS-1:0]  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/ram_sp_arbiter_rr_arbiter2.sv
// Two-input grant logic. RAM_ARB_RR_EN selects round-robin (pointer moves on each grant);
// otherwise port 0 wins every tie and no pointer state exists.
module rr_arbiter2
    import ram_arb_pkg::*;
(
`ifdef RAM_ARB_RR_EN
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 advance,
`endif
    input  logic [NUM_PORTS-1:0] req,
    output logic [NUM_PORTS-1:0] grant
);

`ifdef RAM_ARB_RR_EN
    port_id_t prio;

    always_comb begin
        grant = '0;
        if (prio == 1'b0) begin
            grant[0] = req[0];
            grant[1] = req[1] & ~req[0];
        end else begin
            grant[1] = req[1];
            grant[0] = req[0] & ~req[1];
        end
    end

    // The port just served drops to lowest priority for the next grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= '0;
        end else if (advance) begin
            prio <= ~grant_to_id(grant);
        end
    end
`else
    assign grant = {req[1] & ~req[0], req[0]};
`endif

endmodule

// File: rtl/ram_sp_arbiter.sv
// Shares one synchronous-read single-port RAM between a fetch port (0) and a load/store port (1).
// Optional macro RAM_ARB_RR_EN switches arbitration from fixed priority to round-robin.
module ram_sp_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32
)(
    input  logic                  clk,
    input  logic                  rst_n,
    ram_sp_arbiter_if.slave       req_if,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data
);

    state_t                state;
    port_id_t              port_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [NUM_PORTS-1:0]  grant;
    logic [NUM_PORTS-1:0]  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  accept;

    rr_arbiter2 u_arb (
`ifdef RAM_ARB_RR_EN
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (accept),
`endif
        .req     (req_if.req_valid),
        .grant   (grant)
    );

    // Ready is held low while in reset so nothing can handshake against a stalled controller.
    assign req_if.req_ready = (rst_n && state == IDLE) ? grant : '0;
    assign accept           = |req_if.req_ready;
    assign req_if.rsp_valid = rsp_valid_q;
    assign req_if.rsp_rdata = rsp_rdata_q;
    assign ram_data         = ram_we ? wdata_q : 'z;

    // Controller FSM; RAM controls are registered so they change only at edges (or on reset).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            port_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            ram_cs      <= 1'b0;
            ram_we      <= 1'b0;
            ram_oe      <= 1'b0;
            ram_addr    <= '0;
        end else begin
            rsp_valid_q <= '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        port_q   <= grant_to_id(grant);
                        ram_cs   <= 1'b1;
                        ram_addr <= grant[1] ? req_if.req_addr1 : req_if.req_addr0;
                        if (grant[1] ? req_if.req_we[1] : req_if.req_we[0]) begin
                            state   <= WR;
                            ram_we  <= 1'b1;
                            wdata_q <= grant[1] ? req_if.req_wdata1 : req_if.req_wdata0;
                        end else begin
                            state  <= RD_ADDR;
                            ram_oe <= 1'b1;
                        end
                    end
                end
                RD_ADDR: begin
                    state <= RD_DATA;
                end
                RD_DATA: begin
                    rsp_rdata_q         <= ram_data;
                    rsp_valid_q[port_q] <= 1'b1;
                    ram_cs              <= 1'b0;
                    ram_oe              <= 1'b0;
                    state               <= IDLE;
                end
                WR: begin
                    rsp_valid_q[port_q] <= 1'b1;
                    ram_cs              <= 1'b0;
                    ram_we              <= 1'b0;
                    state               <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_sp_arbiter.sv
// Self-checking bench for ram_sp_arbiter with a synchronous-read RAM model on the tri-state bus.
`timescale 1ns/1ps
module tb_ram_sp_arbiter;
    import ram_arb_pkg::*;

    localparam int DW = 64;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ram_cs;
    logic          ram_we;
    logic          ram_oe;
    logic [AW-1:0] ram_addr;
    wire  [DW-1:0] ram_data;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    ram_sp_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) req_if ();

    ram_sp_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_if   (req_if.slave),
        .ram_cs   (ram_cs),
        .ram_we   (ram_we),
        .ram_oe   (ram_oe),
        .ram_addr (ram_addr),
        .ram_data (ram_data)
    );

    // RAM model: word captured on the address edge, driven onto the bus while oe is high.
    logic [DW-1:0] mem [logic [AW-1:0]];
    logic [DW-1:0] ram_rd_q = '0;

    assign ram_data = (ram_cs && ram_oe && !ram_we) ? ram_rd_q : 'z;

    always @(posedge clk) begin
        if (ram_cs && ram_we) mem[ram_addr] = ram_data;
        if (ram_cs && !ram_we) ram_rd_q <= mem.exists(ram_addr) ? mem[ram_addr] : '0;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Bus ownership and control exclusivity are checked on every cycle out of reset.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            checkOutput("no_oe_and_we", 64'(ram_oe && ram_we), 64'd0);
            if (ram_cs && ram_oe && !ram_we) checkOutput("bus_read_owner", ram_data, ram_rd_q);
        end
    end

    task automatic applyStimulus(input int port, input logic we, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata, output int lat, output logic [DW-1:0] rdata);
        int n;
        if (port == 0) begin
            req_if.req_addr0  = addr;
            req_if.req_wdata0 = wdata;
        end else begin
            req_if.req_addr1  = addr;
            req_if.req_wdata1 = wdata;
        end
        req_if.req_we[port]    = we;
        req_if.req_valid[port] = 1'b1;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (req_if.req_ready[port]) break;
            n++;
        end
        checkOutput("accept_timeout", 64'(n >= 20), 64'd0);
        @(posedge clk);
        #1;
        req_if.req_valid[port] = 1'b0;
        lat   = 1;
        rdata = '0;
        while (lat < 10) begin
            @(negedge clk);
            if (lat == 1) begin
                checkOutput("access_cs", 64'(ram_cs), 64'd1);
                checkOutput("access_we", 64'(ram_we), 64'(we));
                checkOutput("access_oe", 64'(ram_oe), 64'(!we));
                checkOutput("access_addr", 64'(ram_addr), 64'(addr));
                if (we) checkOutput("wr_bus_data", ram_data, wdata);
            end
            if (req_if.rsp_valid[port]) begin
                rdata = req_if.rsp_rdata;
                checkOutput("rsp_port", 64'(req_if.rsp_valid), 64'(2'b01 << port));
                break;
            end
            lat++;
        end
    endtask

    typedef struct {
        int            port;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            exp_lat;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int            lat;
        int            n;
        int            gcount;
        int            gseq[4];
        logic [DW-1:0] rdata;

        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int            lat;
        int            n;
        int            gcount;
        int            gseq[4];
        logic [DW-1:0] rdata;

        vecs[0] = '{1, 1'b1, 32'h10,       64'hDEAD_BEEF,             2, 64'h0};
        vecs[1] = '{0, 1'b0, 32'h10,       64'h0,                     3, 64'hDEAD_BEEF};
        vecs[2] = '{0, 1'b1, 32'h11,       64'h0123_4567_89AB_CDEF,   2, 64'h0};
        vecs[3] = '{1, 1'b0, 32'h11,       64'h0,                     3, 64'h0123_4567_89AB_CDEF};
        vecs[4] = '{1, 1'b1, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,  2, 64'h0};
        vecs[5] = '{0, 1'b0, 32'hFFFF_FFFF, 64'h0,                    3, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[6] = '{0, 1'b1, 32'h0,        64'h0,                     2, 64'h0};
        vecs[7] = '{1, 1'b0, 32'h0,        64'h0,                     3, 64'h0};

        // Reset with both requests pending: ready must stay low and outputs idle.
        req_if.req_valid  = 2'b11;
        req_if.req_we     = 2'b00;
        req_if.req_addr0  = '0;
        req_if.req_addr1  = '0;
        req_if.req_wdata0 = '0;
        req_if.req_wdata1 = '0;
        mem[32'h0] = 64'h5555_AAAA_5555_AAAA;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_req_ready", 64'(req_if.req_ready), 64'd0);
        checkOutput("rst_rsp_valid", 64'(req_if.rsp_valid), 64'd0);
        checkOutput("rst_rsp_rdata", req_if.rsp_rdata, 64'd0);
        checkOutput("rst_ram_cs", 64'(ram_cs), 64'd0);
        checkOutput("rst_ram_we", 64'(ram_we), 64'd0);
        checkOutput("rst_ram_oe", 64'(ram_oe), 64'd0);
        checkOutput("rst_ram_addr", 64'(ram_addr), 64'd0);
        req_if.req_valid = 2'b00;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, rdata);
            checkOutput($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            if (!vecs[i].we) checkOutput($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            @(posedge clk);
            #1;
        end

        // Arbitration: both ports read continuously from a fresh reset (pointer at port 0).
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        mem[32'h20] = 64'h2020_2020_AAAA_0000;
        mem[32'h30] = 64'h3030_3030_BBBB_1111;
        req_if.req_addr0 = 32'h20;
        req_if.req_addr1 = 32'h30;
        req_if.req_we    = 2'b00;
        req_if.req_valid = 2'b11;
        gcount = 0;
        for (int c = 0; c < 40 && gcount < 4; c++) begin
            @(negedge clk);
            if (req_if.rsp_valid[0]) checkOutput("arb_rdata0", req_if.rsp_rdata, 64'h2020_2020_AAAA_0000);
            if (req_if.rsp_valid[1]) checkOutput("arb_rdata1", req_if.rsp_rdata, 64'h3030_3030_BBBB_1111);
            if (req_if.req_ready != 2'b00) begin
                checkOutput("arb_ready_onehot", 64'($countones(req_if.req_ready)), 64'd1);
                gseq[gcount] = int'(req_if.req_ready[1]);
                gcount++;
            end
        end
        checkOutput("arb_grant_count", 64'(gcount), 64'd4);
        @(posedge clk);
        #1;
        req_if.req_valid = 2'b00;
        for (int k = 0; k < 4; k++) begin
`ifdef RAM_ARB_RR_EN
            checkOutput($sformatf("arb_grant%0d", k), 64'(gseq[k]), 64'(k % 2));
`else
            checkOutput($sformatf("arb_grant%0d", k), 64'(gseq[k]), 64'd0);
`endif
        end
        repeat (5) @(posedge clk);
        #1;

        // Back-to-back on port 0: write then read the same word with valid held.
        req_if.req_addr0  = 32'h5;
        req_if.req_wdata0 = 64'hCAFE_F00D_1234_5678;
        req_if.req_we[0]  = 1'b1;
        req_if.req_valid[0] = 1'b1;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (req_if.req_ready[0]) break;
            n++;
        end
        checkOutput("b2b_accept_timeout", 64'(n >= 20), 64'd0);
        @(posedge clk);
        #1;
        req_if.req_we[0] = 1'b0;
        @(negedge clk);
        checkOutput("b2b_wr_ready_low", 64'(req_if.req_ready), 64'd0);
        checkOutput("b2b_wr_bus", ram_data, 64'hCAFE_F00D_1234_5678);
        @(negedge clk);
        checkOutput("b2b_wr_rsp", 64'(req_if.rsp_valid), 64'b01);
        checkOutput("b2b_rd_accept", 64'(req_if.req_ready), 64'b01);
        @(posedge clk);
        #1;
        req_if.req_valid[0] = 1'b0;
        @(negedge clk);
        checkOutput("b2b_rsp_gap1", 64'(req_if.rsp_valid), 64'd0);
        @(negedge clk);
        checkOutput("b2b_rsp_gap2", 64'(req_if.rsp_valid), 64'd0);
        @(negedge clk);
        checkOutput("b2b_rd_rsp", 64'(req_if.rsp_valid), 64'b01);
        checkOutput("b2b_rd_data", req_if.rsp_rdata, 64'hCAFE_F00D_1234_5678);
        @(posedge clk);
        #1;

        // Reset pulsed during a write: chip select drops at once and the word is untouched.
        mem[32'h40] = 64'h0000_0000_0BAD_0BAD;
        req_if.req_addr1  = 32'h40;
        req_if.req_wdata1 = 64'h1111_2222_3333_4444;
        req_if.req_we[1]  = 1'b1;
        req_if.req_valid[1] = 1'b1;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (req_if.req_ready[1]) break;
            n++;
        end
        checkOutput("rstwr_accept_timeout", 64'(n >= 20), 64'd0);
        @(posedge clk);
        #1;
        req_if.req_valid[1] = 1'b0;
        checkOutput("rstwr_in_wr", 64'(ram_cs && ram_we), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rstwr_cs_async", 64'(ram_cs), 64'd0);
        checkOutput("rstwr_we_async", 64'(ram_we), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("rstwr_mem_kept", mem[32'h40], 64'h0000_0000_0BAD_0BAD);
        checkOutput("rstwr_no_rsp", 64'(req_if.rsp_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("rstwr_no_rsp_after", 64'(req_if.rsp_valid), 64'd0);

        applyStimulus(1, 1'b1, 32'h40, 64'h1111_2222_3333_4444, lat, rdata);
        checkOutput("post_rst_wr_latency", 64'(lat), 64'd2);
        @(posedge clk);
        #1;
        applyStimulus(0, 1'b0, 32'h40, 64'h0, lat, rdata);
        checkOutput("post_rst_rd_latency", 64'(lat), 64'd3);
        checkOutput("post_rst_rd_data", rdata, 64'h1111_2222_3333_4444);

        repeat (2) @(posedge clk);
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
